// File: rtl/scoap_comparator_tpi.sv
// Dual equality comparator: baseline datapath beside a copy carrying one OR
// control point on eq_ab and one observation point, for cycle-by-cycle DFT comparison.

// WIDTH-bit equality as an explicit per-bit XNOR row feeding an AND chain,
// so every XNOR output and every partial product is its own named net.
module scoap_eq_tree #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    output logic             eq_o
);
    logic [WIDTH-1:0] xnor_bit;
    logic [WIDTH-1:0] and_chain;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            assign xnor_bit[i] = x_i[i] ~^ y_i[i];
            if (i == 0) begin : g_head
                assign and_chain[i] = xnor_bit[i];
            end else begin : g_link
                assign and_chain[i] = and_chain[i-1] & xnor_bit[i];
            end
        end
    endgenerate

    assign eq_o = and_chain[WIDTH-1];
endmodule

module scoap_comparator_tpi #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic             test_mode,
    output logic             y_base,
    output logic             y_tpi,
    output logic             obs
);
    logic base_eq_ab, base_eq_cd;
    logic tpi_eq_ab,  tpi_eq_cd;
    logic cp_ab;
    logic y_base_d, y_tpi_d, obs_d;
    logic y_base_q, y_tpi_q, obs_q;

    // Baseline trees.
    scoap_eq_tree #(.WIDTH(WIDTH)) u_base_ab (.x_i(a), .y_i(b), .eq_o(base_eq_ab));
    scoap_eq_tree #(.WIDTH(WIDTH)) u_base_cd (.x_i(c), .y_i(d), .eq_o(base_eq_cd));

    // TPI trees are separate instances so the two datapaths share no nets.
    scoap_eq_tree #(.WIDTH(WIDTH)) u_tpi_ab  (.x_i(a), .y_i(b), .eq_o(tpi_eq_ab));
    scoap_eq_tree #(.WIDTH(WIDTH)) u_tpi_cd  (.x_i(c), .y_i(d), .eq_o(tpi_eq_cd));

    // OR control point forces eq_ab to 1 in test mode; the observation point
    // keeps the masked eq_ab node visible.
    assign cp_ab    = tpi_eq_ab | test_mode;
    assign y_base_d = base_eq_ab & base_eq_cd;
    assign y_tpi_d  = cp_ab & tpi_eq_cd;
    assign obs_d    = test_mode & tpi_eq_ab;

    always_ff @(posedge clk) begin
        if (rst) begin
            y_base_q <= 1'b0;
            y_tpi_q  <= 1'b0;
            obs_q    <= 1'b0;
        end else begin
            y_base_q <= y_base_d;
            y_tpi_q  <= y_tpi_d;
            obs_q    <= obs_d;
        end
    end

    assign y_base = y_base_q;
    assign y_tpi  = y_tpi_q;
    assign obs    = obs_q;
endmodule

// File: tb/tb_scoap_comparator_tpi.sv
// Directed and random checks of the baseline/TPI comparator against hand values
// and a small behavioural reference.
module tb_scoap_comparator_tpi;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a, b, c, d;
    logic         test_mode;
    logic         y_base, y_tpi, obs;

    int nvec = 0;
    int nerr = 0;

    scoap_comparator_tpi #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
        .test_mode(test_mode), .y_base(y_base), .y_tpi(y_tpi), .obs(obs)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic got, input logic exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic eb, input logic et, input logic eo);
        chk({tag, ".y_base"}, y_base, eb);
        chk({tag, ".y_tpi"},  y_tpi,  et);
        chk({tag, ".obs"},    obs,    eo);
    endtask

    task automatic drive(input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic [W-1:0] vc, input logic [W-1:0] vd, input logic tm);
        a = va; b = vb; c = vc; d = vd; test_mode = tm;
    endtask

    initial begin
        logic ref_ab, ref_cd, ref_base;

        // Reset holds all outputs low even with matching operands in test mode.
        rst = 1'b1;
        drive(4'h5, 4'h5, 4'h5, 4'h5, 1'b1);
        step(); chk3("reset1", 1'b0, 1'b0, 1'b0);
        step(); chk3("reset2", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step(); chk3("post_reset", 1'b1, 1'b1, 1'b1);

        // Functional match / mismatch.
        drive(4'h3, 4'h3, 4'hA, 4'hA, 1'b0);
        step(); chk3("func_match", 1'b1, 1'b1, 1'b0);
        d = 4'hB;
        step(); chk3("func_mismatch", 1'b0, 1'b0, 1'b0);

        // Control point.
        drive(4'h1, 4'h2, 4'h7, 4'h7, 1'b1);
        step(); chk3("cp_force", 1'b0, 1'b1, 1'b0);
        d = 4'h6;
        step(); chk3("cp_cd_miss", 1'b0, 1'b0, 1'b0);

        // Observation point.
        drive(4'hF, 4'hF, 4'h0, 4'h1, 1'b1);
        step(); chk3("obs_point", 1'b0, 1'b0, 1'b1);

        // Mode switch, one-cycle latency, no settling cycle.
        drive(4'h4, 4'h5, 4'h9, 4'h9, 1'b0);
        step(); chk3("mode0", 1'b0, 1'b0, 1'b0);
        test_mode = 1'b1;
        step(); chk3("mode1", 1'b0, 1'b1, 1'b0);
        test_mode = 1'b0;
        step(); chk3("mode0b", 1'b0, 1'b0, 1'b0);

        // Reset mid-operation discards the pending match.
        drive(4'hC, 4'hC, 4'h2, 4'h2, 1'b1);
        step(); chk3("pre_midrst", 1'b1, 1'b1, 1'b1);
        rst = 1'b1;
        step(); chk3("midrst", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step(); chk3("post_midrst", 1'b1, 1'b1, 1'b1);

        // Random equivalence, operands biased toward equality so both branches hit.
        for (int m = 0; m < 2; m++) begin
            for (int n = 0; n < 100; n++) begin
                a = W'($urandom);
                b = ($urandom_range(0, 1) == 0) ? a : W'($urandom);
                c = W'($urandom);
                d = ($urandom_range(0, 1) == 0) ? c : W'($urandom);
                test_mode = (m == 1);
                ref_ab   = (a == b);
                ref_cd   = (c == d);
                ref_base = ref_ab & ref_cd;
                step();
                chk("rnd.y_base", y_base, ref_base);
                if (m == 0) begin
                    chk("rnd0.y_tpi", y_tpi, ref_base);
                    chk("rnd0.obs",   obs,   1'b0);
                end else begin
                    chk("rnd1.y_tpi", y_tpi, ref_cd);
                    chk("rnd1.obs",   obs,   ref_ab);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
